// File: rtl/dmem_run_arbiter_pkg.sv
// Shared encodings for the data-memory run arbiter: FSM states and the
// status codes polled by the control unit's END state.
package dmem_run_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4
  } arb_state_t;

  localparam logic [1:0] STAT_IDLE  = 2'b00;
  localparam logic [1:0] STAT_START = 2'b01;
  localparam logic [1:0] STAT_RUN   = 2'b10;

endpackage

// File: rtl/dmem_run_arbiter_if.sv
// Host byte streams, processor memory lines and the RAM port seen by the arbiter.
// slave = arbiter side, master = surrounding host/processor/RAM side.
interface dmem_run_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_we;
  logic              proc_end;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_in_data, host_in_valid, host_out_ready,
    input  proc_addr, proc_wdata, proc_we, proc_end, mem_rdata,
    output host_in_ready, host_out_data, host_out_valid,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output host_in_data, host_in_valid, host_out_ready,
    output proc_addr, proc_wdata, proc_we, proc_end, mem_rdata,
    input  host_in_ready, host_out_data, host_out_valid,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_run_arbiter_port_mux.sv
// Combinational host/processor select for a single RAM port's address,
// write data and write enable.
module dmem_port_mux #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel_proc,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we
);

  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = host_we;
    if (sel_proc) begin
      mem_addr  = proc_addr;
      mem_wdata = proc_wdata;
      mem_we    = proc_we;
    end
  end

endmodule

// File: rtl/dmem_run_arbiter.sv
// Schedules one job on the data-memory port: host load, processor run, result readback.
// Optional RUN watchdog enabled by defining ARB_TIMEOUT_EN.
module dmem_run_arbiter
  import dmem_run_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMG_SIZE = 65536,
  parameter int unsigned OUT_BASE = 0,
  parameter int unsigned OUT_SIZE = 16384
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_start,
  dmem_run_arbiter_if.slave    bus,
  output logic [1:0]           status,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned        CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0]   IMG_LAST   = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0]   OUT_LAST   = CNT_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0]  OUT_BASE_A = ADDR_W'(OUT_BASE);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              cap_q;
  logic [DATA_W-1:0] out_q;

  logic              load_fire;
  logic              out_fire;
  logic              sel_proc;
  logic [ADDR_W-1:0] host_addr;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] run_cnt;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign load_fire = in_ready_q & bus.host_in_valid;
  assign out_fire  = out_valid_q & bus.host_out_ready;
  assign sel_proc  = (state == ST_RUN);

  // An accepted readback byte issues the next read in the same cycle to keep 2 cycles/byte.
  always_comb begin
    host_addr = cnt[ADDR_W-1:0];
    if (state == ST_UNLOAD) host_addr = OUT_BASE_A + cnt[ADDR_W-1:0] + ADDR_W'(out_fire);
  end

  dmem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_mux (
    .sel_proc   (sel_proc),
    .host_addr  (host_addr),
    .host_wdata (bus.host_in_data),
    .host_we    (load_fire),
    .proc_addr  (bus.proc_addr),
    .proc_wdata (bus.proc_wdata),
    .proc_we    (bus.proc_we),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .mem_we     (bus.mem_we)
  );

  assign bus.host_in_ready  = in_ready_q;
  assign bus.host_out_valid = out_valid_q;
  assign bus.host_out_data  = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cap_q       <= 1'b0;
      out_q       <= '0;
      status      <= STAT_IDLE;
      busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      run_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (job_start) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == IMG_LAST) begin
              state      <= ST_START;
              in_ready_q <= 1'b0;
              status     <= STAT_START;
            end
          end
        end
        ST_START: begin
          state  <= ST_RUN;
          status <= STAT_RUN;
`ifdef ARB_TIMEOUT_EN
          run_cnt <= '0;
`endif
        end
        ST_RUN: begin
          if (bus.proc_end) begin
            state       <= ST_UNLOAD;
            cnt         <= '0;
            cap_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (run_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state  <= ST_IDLE;
            status <= STAT_IDLE;
            busy   <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
`endif
        end
        ST_UNLOAD: begin
          // Phases: issue (neither flag), capture (cap_q), present (out_valid_q).
          if (cap_q) begin
            out_q       <= bus.mem_rdata;
            out_valid_q <= 1'b1;
            cap_q       <= 1'b0;
          end else if (!out_valid_q) begin
            cap_q <= 1'b1;
          end else if (bus.host_out_ready) begin
            out_valid_q <= 1'b0;
            if (cnt == OUT_LAST) begin
              state  <= ST_IDLE;
              status <= STAT_IDLE;
              busy   <= 1'b0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              cap_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          status <= STAT_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_run_arbiter.md
Name: dmem_run_arbiter

Overview:
- Owns the single data-memory port and schedules one processor run per job: host image load, processor start, wait for completion, then host readback of the downsampled result.
- Multiplexes the memory between the host byte stream (LOAD/UNLOAD phases) and the processor datapath (RUN phase).
- Drives the 2-bit status word the control unit polls in its END state.
- Sits between the host/UART bridge, the data RAM and the processor core.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory/pixel width.
- IMG_SIZE, 65536, bytes loaded from host starting at address 0 (1..2^ADDR_W).
- OUT_BASE, 0, first result address read back.
- OUT_SIZE, 16384, bytes read back (1..2^ADDR_W-OUT_BASE).
- TIMEOUT_CYCLES, 2^24, watchdog limit (feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  pulse; begins a job when idle
- host_in_data  in  DATA_W  load byte
- host_in_valid  in  1  load byte valid
- host_in_ready  out  1  arbiter accepts load byte
- host_out_data  out  DATA_W  readback byte
- host_out_valid  out  1  readback byte valid
- host_out_ready  in  1  host accepts readback byte
- proc_addr  in  ADDR_W  processor memory address
- proc_wdata  in  DATA_W  processor write data
- proc_we  in  1  processor write enable
- proc_end  in  1  processor reached END (one-cycle pulse)
- status  out  2  00 idle/done, 01 start, 10 running
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
- busy  out  1  job in progress
- err  out  1  sticky watchdog abort (feature only, else tied 0)

Behaviour:
- Reset (async, rst_n low): state IDLE; status=00; all ready/valid/we=0; mem_addr=0; counters=0; busy=0; err=0. Reset mid-job abandons the job; no further memory writes occur.
- FSM states:
  - IDLE: busy=0. On job_start go to LOAD and clear the counter; job_start in any other state is ignored.
  - LOAD: host_in_ready=1. On valid&&ready, write the byte: mem_we=1, mem_addr=cnt, cnt++ (same cycle, combinational path through to the RAM). After byte IMG_SIZE-1 go to START.
  - START: one cycle, status=01, then RUN.
  - RUN: status=10. mem_addr/mem_wdata/mem_we mux combinationally from proc_*; host ready/valid=0. On proc_end go to UNLOAD, cnt=0.
  - UNLOAD: issue read at OUT_BASE+cnt, next cycle capture mem_rdata into an output register and assert host_out_valid. Hold data stable until host_out_ready, then cnt++ and issue the next read. Peak throughput one byte per 2 cycles. After byte OUT_SIZE-1 is accepted go to IDLE with status=00.
- busy=1 in every state except IDLE.
- The counter is ADDR_W+1 bits wide, so IMG_SIZE=2^ADDR_W terminates without wrap. Address arithmetic is modulo 2^ADDR_W.
- proc_end outside RUN is ignored. proc_end in the START cycle is ignored.
- The host may hold host_out_ready high continuously; valid never asserts during the read-issue cycle.
- mem_we is forced 0 outside LOAD and RUN.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a RUN-cycle counter exists. Reaching TIMEOUT_CYCLES without proc_end forces IDLE, status=00 and sets err. err clears only on the next job_start or reset. UNLOAD is skipped.
- Undefined: no counter; RUN waits indefinitely; err tied 0.

Decomposition:
- Shared package/include: state encodings, status codes (STAT_IDLE=00, STAT_START=01, STAT_RUN=10), which match the control unit's status definitions.
- Natural sub-module: dmem_port_mux, a combinational host/processor select for the address/data/write-enable lines, reused by any instruction-memory loader.

Test Plan:
- IMG_SIZE=4, bytes A0,A1,A2,A3 with valid held high -> RAM[0..3]=A0..A3 in 4 consecutive cycles; status=01 for exactly one cycle, then 10.
- RUN with proc_we=1, proc_addr=0x0010, proc_wdata=5A -> RAM[0x10]=5A; a concurrent host_in_valid is not accepted (ready=0).
- OUT_BASE=0x10, OUT_SIZE=2, host_out_ready toggling 0/1 -> bytes 5A then RAM[0x11] delivered in order, data stable while valid&&!ready; then IDLE, busy=0.
- proc_end pulsed during LOAD, and job_start pulsed during RUN -> both ignored; state and counters unchanged.
- rst_n asserted mid-LOAD after 2 bytes -> immediately IDLE, no further writes; a new job restarts at address 0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no proc_end -> at cycle 100 of RUN: err=1, status=00, state IDLE; next job_start clears err.
